// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the lock-state encoding used by
// the display-enable recovery block.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned H_BACK_DEF      = 48;
  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned V_BACK_DEF      = 33;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned CW_DEF          = 10;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one raw sync input and flags its trailing (active -> inactive) edge
// on the registered sample.
module sync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic level,
  output logic trail_c
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= ~POL;
      level_d <= ~POL;
    end else begin
      level   <= sync_in;
      level_d <= level;
    end
  end

  assign trail_c = (level != POL) && (level_d == POL);

endmodule

// File: rtl/vga_de_recover.sv
// Recovers de/x/y from a raw hsync/vsync/RGB stream, checks line and frame
// lengths, and only releases de once the timing has been proven for several frames.
module vga_de_recover
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned RGB_W       = 3,
  parameter int unsigned CW          = CW_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             de,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic             locked,
  output logic             line_err,
  output logic             frame_err
);

  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned GW  = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

  localparam logic [CW-1:0]  POS_MAX   = '1;
  localparam logic [CW-1:0]  POS_PRE   = POS_MAX - CW'(1);
  localparam logic [CW-1:0]  H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  H_VIS_LO  = CW'(H_BACK);
  localparam logic [CW-1:0]  H_VIS_HI  = CW'(H_BACK + H_ACTIVE);
  localparam logic [CW-1:0]  V_VIS_LO  = CW'(V_BACK);
  localparam logic [CW-1:0]  V_VIS_HI  = CW'(V_BACK + V_ACTIVE);
  localparam logic [CW1-1:0] V_TOT     = CW1'(V_TOTAL);
  localparam logic [GW-1:0]  GOOD_LOCK = GW'(LOCK_FRAMES);

  // Stage 1: registered inputs and edge strobes
  logic             h_level, h_trail_c;
  logic             v_level, v_trail_c;
  logic [RGB_W-1:0] rgb1;

  sync_edge_detect #(.POL(HSYNC_POL)) u_hsync (
    .clk     (clk_pixel),
    .reset   (reset),
    .sync_in (hsync_in),
    .level   (h_level),
    .trail_c (h_trail_c)
  );

  sync_edge_detect #(.POL(VSYNC_POL)) u_vsync (
    .clk     (clk_pixel),
    .reset   (reset),
    .sync_in (vsync_in),
    .level   (v_level),
    .trail_c (v_trail_c)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) rgb1 <= '0;
    else       rgb1 <= rgb_in;
  end

  // Position of the previous stage-1 pixel; the stage-1 pixel's position is derived below
  logic [CW-1:0] h_pos, v_pos;
  logic          first_h, first_v;
  logic [CW-1:0] h_next_c, v_next_c;
  logic          h_sat_c, v_sat_c;
  logic          line_bad_c, frame_bad_c, vis_c;

  assign h_sat_c  = (h_pos == POS_MAX);
  assign v_sat_c  = (v_pos == POS_MAX);
  assign h_next_c = h_trail_c ? '0 : (h_sat_c ? h_pos : h_pos + CW'(1));
  assign v_next_c = v_trail_c ? '0 :
                    (h_trail_c ? (v_sat_c ? v_pos : v_pos + CW'(1)) : v_pos);

  // A saturated line is reported when it saturates, not again at its late edge
  assign line_bad_c  = (h_trail_c && !first_h && !h_sat_c && (h_pos != H_LAST)) ||
                       (!h_trail_c && (h_pos == POS_PRE));
  assign frame_bad_c = v_trail_c && !first_v &&
                       ((CW1'(v_pos) + CW1'(h_trail_c)) != V_TOT);

  assign vis_c = (h_next_c >= H_VIS_LO) && (h_next_c < H_VIS_HI) &&
                 (v_next_c >= V_VIS_LO) && (v_next_c < V_VIS_HI);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_pos   <= POS_MAX;
      v_pos   <= POS_MAX;
      first_h <= 1'b1;
      first_v <= 1'b1;
    end else begin
      h_pos <= h_next_c;
      v_pos <= v_next_c;
      if (h_trail_c) first_h <= 1'b0;
      if (v_trail_c) first_v <= 1'b0;
    end
  end

  // Lock FSM state register
  lock_state_t   state, state_next;
  logic [GW-1:0] good_cnt, good_next;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // Lock FSM next state and the pixel-aligned output values
  logic          de_c;
  logic [CW-1:0] x_c, y_c;

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    de_c       = 1'b0;
    x_c        = '0;
    y_c        = '0;
    unique case (state)
      UNLOCKED: begin
        if (v_trail_c) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (line_bad_c || frame_bad_c) begin
          state_next = UNLOCKED;
        end else if (v_trail_c) begin
          good_next = good_cnt + GW'(1);
          if (good_next == GOOD_LOCK) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad_c || frame_bad_c) state_next = UNLOCKED;
      end
      default: state_next = UNLOCKED;
    endcase
    de_c = vis_c && (state_next == LOCKED);
    if (de_c) begin
      x_c = h_next_c - H_VIS_LO;
      y_c = v_next_c - V_VIS_LO;
    end
  end

  // Stage 2: output registers, all aligned to the same pixel
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hsync_out <= ~HSYNC_POL;
      vsync_out <= ~VSYNC_POL;
      rgb_out   <= '0;
      de        <= 1'b0;
      x         <= '0;
      y         <= '0;
      locked    <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      hsync_out <= h_level;
      vsync_out <= v_level;
      rgb_out   <= de_c ? rgb1 : '0;
      de        <= de_c;
      x         <= x_c;
      y         <= y_c;
      locked    <= (state_next == LOCKED);
      line_err  <= line_bad_c;
      frame_err <= frame_bad_c;
    end
  end

endmodule

// File: tb/tb_vga_de_recover.sv
// Bench for vga_de_recover: a scaled-down 16x12 raster drives an active-low and
// an active-high instance; every output pixel is compared two cycles after input.
module tb_vga_de_recover;

  localparam int HA = 8;
  localparam int HB = 3;
  localparam int HT = 16;
  localparam int VA = 6;
  localparam int VB = 2;
  localparam int VT = 12;
  localparam int CWB = 5;
  localparam int RW = 3;
  localparam int LF = 2;
  localparam int LONG_LEN = 40;
  localparam int SAT_PX = (1 << CWB) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          hs_in, vs_in, hs_inv, vs_inv;
  logic [RW-1:0] rgb_in;

  assign hs_inv = ~hs_in;
  assign vs_inv = ~vs_in;

  logic           hso_a, vso_a, de_a, lk_a, le_a, fe_a;
  logic [RW-1:0]  rgbo_a;
  logic [CWB-1:0] x_a, y_a;
  logic           hso_b, vso_b, de_b, lk_b, le_b, fe_b;
  logic [RW-1:0]  rgbo_b;
  logic [CWB-1:0] x_b, y_b;

  vga_de_recover #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .RGB_W(RW), .CW(CWB), .LOCK_FRAMES(LF)
  ) u_dut_a (
    .clk_pixel(clk), .reset(reset),
    .hsync_in(hs_in), .vsync_in(vs_in), .rgb_in(rgb_in),
    .hsync_out(hso_a), .vsync_out(vso_a), .rgb_out(rgbo_a),
    .de(de_a), .x(x_a), .y(y_a), .locked(lk_a),
    .line_err(le_a), .frame_err(fe_a)
  );

  vga_de_recover #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .RGB_W(RW), .CW(CWB), .LOCK_FRAMES(LF)
  ) u_dut_b (
    .clk_pixel(clk), .reset(reset),
    .hsync_in(hs_inv), .vsync_in(vs_inv), .rgb_in(rgb_in),
    .hsync_out(hso_b), .vsync_out(vso_b), .rgb_out(rgbo_b),
    .de(de_b), .x(x_b), .y(y_b), .locked(lk_b),
    .line_err(le_b), .frame_err(fe_b)
  );

  // Syncs are held in active-low terms; the active-high instance is compared inverted
  typedef struct packed {
    logic           hs;
    logic           vs;
    logic [RW-1:0]  rgb;
    logic           de;
    logic [CWB-1:0] x;
    logic [CWB-1:0] y;
    logic           locked;
    logic           le;
    logic           fe;
  } out_t;

  typedef struct {
    int nlines;
    int short_ln;
    int long_ln;
    int rst_ln;
    bit fe0;
    bit lk0;
  } frame_t;

  int   checks = 0;
  int   errors = 0;
  out_t q0, q1;
  bit   v0 = 1'b0, v1 = 1'b0;
  int   tag0, tag1;
  bit   cur_lock;

  function automatic out_t reset_exp();
    out_t r;
    r    = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  task automatic check_out(input out_t exp, input int tag);
    out_t act_a, act_b;
    act_a = {hso_a, vso_a, rgbo_a, de_a, x_a, y_a, lk_a, le_a, fe_a};
    act_b = {~hso_b, ~vso_b, rgbo_b, de_b, x_b, y_b, lk_b, le_b, fe_b};
    checks++;
    if (act_a !== exp) begin
      errors++;
      $display("FAIL pol0 pixel %0d (frame*10000+line*100+px): actual=%h required=%h",
               tag, act_a, exp);
    end
    checks++;
    if (act_b !== exp) begin
      errors++;
      $display("FAIL pol1 pixel %0d (frame*10000+line*100+px): actual=%h required=%h",
               tag, act_b, exp);
    end
  endtask

  // Drive one pixel; the pixel driven two calls earlier is checked first
  task automatic put(input logic hs, input logic vs, input logic [RW-1:0] rgb,
                     input logic rst, input out_t exp, input int tag);
    @(negedge clk);
    if (v1) check_out(q1, tag1);
    q1   = q0;
    v1   = v0;
    tag1 = tag0;
    q0   = exp;
    v0   = 1'b1;
    tag0 = tag;
    if (rst) begin
      q0 = reset_exp();
      q1 = reset_exp();
      v1 = 1'b1;
    end
    reset  = rst;
    hs_in  = hs;
    vs_in  = vs;
    rgb_in = rgb;
  endtask

  task automatic send_line(input int fr, input int ln, input int len, input bit vs_act,
                           input int le_px, input bit fe0, input int rst_px);
    for (int px = 0; px < len; px++) begin
      out_t          e;
      logic          hs, vs, rst;
      logic [RW-1:0] rgb;
      hs  = (px >= len - 2) ? 1'b0 : 1'b1;
      vs  = vs_act ? 1'b0 : 1'b1;
      rgb = RW'(px + ln + fr + 1);
      rst = (px == rst_px);
      e   = '0;
      e.le = (px == le_px);
      if (e.le || rst) cur_lock = 1'b0;
      e.hs     = hs;
      e.vs     = vs;
      e.fe     = (px == 0) && fe0;
      e.locked = cur_lock;
      e.de     = cur_lock && (px >= HB) && (px < HB + HA) && (ln >= VB) && (ln < VB + VA);
      if (e.de) begin
        e.x   = CWB'(px - HB);
        e.y   = CWB'(ln - VB);
        e.rgb = rgb;
      end
      put(hs, vs, rgb, rst, e, fr * 10000 + ln * 100 + px);
    end
  endtask

  task automatic send_frame(input int fr, input frame_t f);
    cur_lock = f.lk0;
    for (int ln = 0; ln < f.nlines; ln++) begin
      int len, le_px, rst_px;
      len    = (ln == f.short_ln) ? HT - 1 : ((ln == f.long_ln) ? LONG_LEN : HT);
      le_px  = -1;
      if (f.short_ln >= 0 && ln == f.short_ln + 1) le_px = 0;
      if (ln == f.long_ln) le_px = SAT_PX;
      rst_px = (ln == f.rst_ln) ? 5 : -1;
      send_line(fr, ln, len, (ln >= f.nlines - 2), le_px, (ln == 0) && f.fe0, rst_px);
    end
  endtask

  frame_t tbl[19];

  initial begin
    reset  = 1'b1;
    hs_in  = 1'b1;
    vs_in  = 1'b1;
    rgb_in = '0;

    // nlines, short line, long line, reset line, frame_err at line 0, locked from line 0
    tbl[0]  = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[1]  = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[2]  = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[3]  = '{VT, -1, -1, -1, 1'b0, 1'b1};
    tbl[4]  = '{VT,  4, -1, -1, 1'b0, 1'b1};
    tbl[5]  = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[6]  = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[7]  = '{VT, -1, -1, -1, 1'b0, 1'b1};
    tbl[8]  = '{VT - 1, -1, -1, -1, 1'b0, 1'b1};
    tbl[9]  = '{VT, -1, -1, -1, 1'b1, 1'b0};
    tbl[10] = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[11] = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[12] = '{VT, -1, -1, -1, 1'b0, 1'b1};
    tbl[13] = '{VT, -1, -1,  4, 1'b0, 1'b1};
    tbl[14] = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[15] = '{VT, -1, -1, -1, 1'b0, 1'b0};
    tbl[16] = '{VT, -1, -1, -1, 1'b0, 1'b1};
    tbl[17] = '{VT, -1,  5, -1, 1'b0, 1'b1};
    tbl[18] = '{VT, -1, -1, -1, 1'b0, 1'b0};

    // Reset with a non-zero colour on the bus: outputs must show reset values
    put(1'b1, 1'b1, 3'b111, 1'b1, reset_exp(), -1);
    put(1'b1, 1'b1, 3'b111, 1'b1, reset_exp(), -2);

    for (int i = 0; i < 19; i++) send_frame(i, tbl[i]);

    // Drain the two pixels still in flight
    @(negedge clk);
    if (v1) check_out(q1, tag1);
    @(negedge clk);
    if (v0) check_out(q0, tag0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_de_recover.md
# vga_de_recover

Recovers display-enable and pixel coordinates from a bare hsync/vsync/RGB stream such as the `uo_out` bus of the TinyTapeout VGA core, for feeding `hdmi_output`. It supersedes the free-running edge counters in the board tops with a parametrised block that:
- honours back porch and sync polarity;
- verifies line and frame lengths;
- gates output on a lock state machine, so `hdmi_output` only sees `de` after timing is proven.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_BACK`, default 48: pixels from hsync trailing edge to first visible pixel.
- `H_TOTAL`, default 800: pixels per line.
- `V_ACTIVE`, default 480: visible lines.
- `V_BACK`, default 33: lines from vsync trailing edge to first visible line.
- `V_TOTAL`, default 525: lines per frame.
- `HSYNC_POL`, default 0: active level of hsync (0 = active-low).
- `VSYNC_POL`, default 0: active level of vsync.
- `RGB_W`, default 3: colour bus width.
- `CW`, default 10: counter width. Must satisfy 2^CW > max(`H_TOTAL`, `V_TOTAL`).
- `LOCK_FRAMES`, default 2: consecutive good frames required to lock.

Ports:
- `clk_pixel` in 1: pixel clock. The block has one clock.
- `reset` in 1: synchronous, active-high.
- `hsync_in` in 1: raw hsync.
- `vsync_in` in 1: raw vsync.
- `rgb_in` in `RGB_W`: raw colour.
- `hsync_out` out 1: hsync delayed to align with `de`.
- `vsync_out` out 1: vsync delayed to align with `de`.
- `rgb_out` out `RGB_W`: colour; forced to 0 when `de`=0.
- `de` out 1: visible pixel and locked.
- `x` out `CW`: pixel column, 0..`H_ACTIVE`-1; 0 when `de`=0.
- `y` out `CW`: pixel row, 0..`V_ACTIVE`-1; 0 when `de`=0.
- `locked` out 1: timing verified.
- `line_err` out 1: one-cycle pulse on a bad line length.
- `frame_err` out 1: one-cycle pulse on a bad frame length.

## Operation
- **Input stage.** Inputs are registered once (stage 1).
  - Sync is "active" when it equals its `*_POL` value.
  - A trailing edge is stage-1 sync inactive while the previous stage-1 sample was active.
- **Horizontal position `h_pos`.**
  - The stage-1 pixel on which an hsync trailing edge is detected has `h_pos`=0.
  - Otherwise `h_pos` = previous `h_pos` + 1, saturating at 2^CW-1.
- **Vertical position `v_pos`.**
  - Incremented on each hsync trailing edge, saturating.
  - Set to 0 on a vsync trailing edge. A vsync edge takes precedence over a coincident hsync edge.
- **Visible region.** `vis` = (`H_BACK` ≤ `h_pos` < `H_BACK`+`H_ACTIVE`) and (`V_BACK` ≤ `v_pos` < `V_BACK`+`V_ACTIVE`).
  - `x` = `h_pos`-`H_BACK`, `y` = `v_pos`-`V_BACK`.
- **Line check.** At each hsync trailing edge (except the first after reset), previous `h_pos`+1 must equal `H_TOTAL`. Saturation of `h_pos` also counts as a mismatch, flagged once.
  - On a mismatch, pulse `line_err`.
- **Frame check.** At each vsync trailing edge (except the first after reset), the count of hsync trailing edges since the previous vsync edge must equal `V_TOTAL`.
  - On a mismatch, pulse `frame_err`.
- **Lock FSM.**
  - `UNLOCKED`: on the first vsync trailing edge go to `ACQUIRE` and clear `good_cnt`.
  - `ACQUIRE`: on each error go to `UNLOCKED`. On each error-free vsync edge increment `good_cnt`; when it reaches `LOCK_FRAMES`, go to `LOCKED`.
  - `LOCKED`: `line_err` or `frame_err` returns to `UNLOCKED`.
  - `locked` is 1 only in `LOCKED`.
- **Output gating.** `de` = `vis` & `locked`.

## Timing
- **Latency.** Fixed 2 cycles from `*_in` to `hsync_out`/`vsync_out`/`rgb_out`/`de`/`x`/`y`, all mutually aligned.
- **Error pulses and lock.**
  - `line_err`/`frame_err` assert in the same cycle as the aligned output of the edge pixel.
  - `locked` changes in that same cycle.
  - `de` is 0 on the erroring pixel.
- **Reset values.**
  - `hsync_out`=~`HSYNC_POL`, `vsync_out`=~`VSYNC_POL`.
  - `rgb_out`, `de`, `x`, `y`, `locked`, `line_err`, `frame_err` all 0.
  - Counters saturated, FSM `UNLOCKED`, first-edge flags set.
- **Reset mid-frame.** Reset takes effect on the next edge: outputs go to their reset values 1 cycle later, and re-lock needs `LOCK_FRAMES`+1 vsync edges.

## Structure
- **Package `vga_timing_pkg`:**
  - 640x480@60 constants (`H_*`/`V_*` defaults above);
  - lock-state enum {`UNLOCKED`, `ACQUIRE`, `LOCKED`};
  - a `CW` default of 10.
- **Sub-module `sync_edge_detect`**, parametrised by `POL`:
  - registers one sync input;
  - emits the stage-1 level and a trailing-edge strobe;
  - instantiated twice.

## Test plan
- **Nominal lock.** Reset, then a nominal 800x525 stream with active-low syncs.
  - `locked` rises at the 3rd vsync trailing edge.
  - Each line then has exactly 640 `de` cycles, starting 48+2 cycles after the hsync trailing edge at the input.
  - `x` runs 0..639; `y` runs 0..479.
- **Short line.** Locked stream, one line of 799 pixels.
  - `line_err` pulses once and `locked` drops.
  - After 2 clean frames `locked` returns.
- **Polarity.** `HSYNC_POL`=`VSYNC_POL`=1 with inverted syncs → behaviour identical to the nominal case; reset values of `hsync_out`/`vsync_out` are 0.
- **Short frame.** Locked stream, one frame of 524 lines → a single `frame_err` pulse, `locked`=0, no `line_err`.
- **Coincident edges.** Hsync and vsync trailing edges in the same cycle → `v_pos`=0 (not 1); the first visible row is `y`=0, 33 lines later.
- **Reset mid-frame.** Assert `reset` for 1 cycle at line 200.
  - All outputs are at their reset values in the next cycle.
  - `de` stays 0 until lock is regained.
